// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot sequencer for the single-cycle RISC-V CPU.
// Holds the CPU in reset, receives a length-prefixed byte image over a
// valid/ready handshake, and assembles little-endian 32-bit words. It writes
// those words into instruction memory from word 0 upward, then releases the
// CPU. Define BOOT_CHECKSUM_EN to add a trailing mod-256 payload checksum byte.
module imem_boot_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reload,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
`ifdef BOOT_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_RUN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   // State entered once the payload (or an empty image) has been consumed.
`ifdef BOOT_CHECKSUM_EN
   localparam state_t S_AFTER_DATA = S_CSUM;
`else
   localparam state_t S_AFTER_DATA = S_RUN;
`endif

   state_t          r_state;
   state_t          w_next;
   logic [15:0]     r_count;      // word count N
   logic [ADDR_W:0] r_idx;        // next word index; one extra bit so N = 2^ADDR_W fits
   logic [1:0]      r_lane;       // byte lane within the current word
   logic [23:0]     r_word;       // first three bytes of the word in progress
   logic            r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]     r_wdata;
   logic            r_cpu_reset;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]      r_csum;
`endif

   logic            w_rx_ready;
   logic            w_done;
   logic            w_error;
   logic            w_hs;
   logic [15:0]     w_count_full;
   logic            w_too_big;
   logic [ADDR_W:0] w_idx_inc;
   logic            w_last;

   assign w_hs         = rx_valid & w_rx_ready;
   assign w_count_full = {rx_data, r_count[7:0]};
   assign w_too_big    = {1'b0, w_count_full} > (17'd1 << ADDR_W);
   assign w_idx_inc    = r_idx + 1'b1;
   assign w_last       = (17'(w_idx_inc) == {1'b0, r_count});

   // State register; synchronous reset returns to LEN0.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (reset) r_state <= S_LEN0;
      else       r_state <= w_next;
   end

   // Next-state logic: reload overrides any handshake in the same cycle.
   always_comb begin
      // NOTE: default assignment first so no path leaves w_next unassigned,
      // which would otherwise infer a latch.
      w_next = r_state;
      if (reload) begin
         w_next = S_LEN0;
      end else if (w_hs) begin
         case (r_state)
            S_LEN0: w_next = S_LEN1;
            S_LEN1: begin
               if (w_too_big)                 w_next = S_ERR;
               else if (w_count_full == 16'd0) w_next = S_AFTER_DATA;
               else                           w_next = S_DATA;
            end
            S_DATA: if (r_lane == 2'd3 && w_last) w_next = S_AFTER_DATA;
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: w_next = (rx_data == r_csum) ? S_RUN : S_ERR;
`endif
            default: w_next = r_state;
         endcase
      end
   end

   // Output decode from the registered state only (no path from rx_valid).
   always_comb begin
      w_rx_ready = 1'b0;
      w_done     = 1'b0;
      w_error    = 1'b0;
      case (r_state)
         S_LEN0, S_LEN1, S_DATA: w_rx_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         S_CSUM: w_rx_ready = 1'b1;
`endif
         S_RUN:  w_done     = 1'b1;
         S_ERR:  w_error    = 1'b1;
         default: ;
      endcase
   end

   // Datapath: count capture, word assembly, write strobe and CPU reset stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count     <= '0;
         r_idx       <= '0;
         r_lane      <= '0;
         r_word      <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_reset <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         // One stage behind the state so the final write lands before release.
         r_cpu_reset <= reload | (r_state != S_RUN);
         if (reload) begin
            r_idx  <= '0;
            r_lane <= '0;
            r_word <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_csum <= '0;
`endif
         end else if (w_hs) begin
            case (r_state)
               S_LEN0: r_count[7:0] <= rx_data;
               S_LEN1: r_count      <= w_count_full;
               S_DATA: begin
                  r_lane <= r_lane + 2'd1;
                  r_word <= {rx_data, r_word[23:8]};
`ifdef BOOT_CHECKSUM_EN
                  r_csum <= r_csum + rx_data;
`endif
                  if (r_lane == 2'd3) begin
                     r_we    <= 1'b1;
                     r_addr  <= r_idx[ADDR_W-1:0];
                     r_wdata <= {rx_data, r_word};
                     r_idx   <= w_idx_inc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ready   = w_rx_ready;
   assign done       = w_done;
   assign error      = w_error;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign cpu_reset  = r_cpu_reset;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader (ADDR_W = 8). Checksum-specific
// stimulus is compiled in when BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              reload;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [ADDR_W-1:0] log_addr[$];
   logic [31:0]       log_data[$];
   int                log_cyc[$];

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .reload    (reload),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every write pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         log_addr.push_back(imem_addr);
         log_data.push_back(imem_wdata);
         log_cyc.push_back(cyc);
      end
   end

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      n_checks++;
      if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready: rx_ready=%b required 1 for byte %h", rx_ready, b); end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; reload = 1'b0; rx_valid = 1'b1; rx_data = 8'h05;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (rx_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
      n_checks++; if (cpu_reset !== 1'b1)   begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
      n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (error !== 1'b0)       begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
      n_checks++; if (imem_we !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %b want 0", imem_we); end
      n_checks++; if (imem_addr !== '0)     begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      n_checks++; if (imem_wdata !== '0)    begin n_fail++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
      rx_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      clear_log();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
      send_byte(8'h73); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      n_checks++; if (imem_we !== 1'b1)            begin n_fail++; $display("FAIL basic_last_we: got %b want 1", imem_we); end
      n_checks++; if (imem_addr !== 8'h01)         begin n_fail++; $display("FAIL basic_last_addr: got %h want 01", imem_addr); end
      n_checks++; if (imem_wdata !== 32'h00100073) begin n_fail++; $display("FAIL basic_last_wdata: got %h want 00100073", imem_wdata); end
`ifdef BOOT_CHECKSUM_EN
      send_byte(8'hEB);
`endif
      n_checks++; if (done !== 1'b1)      begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
      n_checks++; if (rx_ready !== 1'b0)  begin n_fail++; $display("FAIL basic_rx_ready: got %b want 0", rx_ready); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL basic_cpu_reset_e0: got %b want 1", cpu_reset); end
      @(posedge clk); #1;
      n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_reset_e1: got %b want 0", cpu_reset); end
      n_checks++; if (imem_we !== 1'b0)   begin n_fail++; $display("FAIL basic_we_after: got %b want 0", imem_we); end
      n_checks++;
      if (log_addr.size() != 2) begin
         n_fail++; $display("FAIL basic_write_count: got %0d want 2", log_addr.size());
      end else begin
         n_checks += 4;
         if (log_addr[0] !== 8'h00)         begin n_fail++; $display("FAIL basic_addr0: got %h want 00", log_addr[0]); end
         if (log_data[0] !== 32'h00500513)  begin n_fail++; $display("FAIL basic_data0: got %h want 00500513", log_data[0]); end
         if (log_addr[1] !== 8'h01)         begin n_fail++; $display("FAIL basic_addr1: got %h want 01", log_addr[1]); end
         if (log_cyc[1] - log_cyc[0] != 4)  begin n_fail++; $display("FAIL basic_spacing: got %0d want 4", log_cyc[1] - log_cyc[0]); end
      end
   endtask

   task automatic test_zero();
      do_reload();
      n_checks++; if (rx_ready !== 1'b1)  begin n_fail++; $display("FAIL zero_reload_ready: got %b want 1", rx_ready); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL zero_reload_cpu_reset: got %b want 1", cpu_reset); end
      n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL zero_reload_done: got %b want 0", done); end
      clear_log();
      send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
      send_byte(8'h00);
`endif
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
      repeat (2) @(posedge clk); #1;
      n_checks++; if (cpu_reset !== 1'b0)   begin n_fail++; $display("FAIL zero_cpu_reset: got %b want 0", cpu_reset); end
      n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", log_addr.size()); end
   endtask

   task automatic test_overflow();
      do_reload();
      clear_log();
      send_byte(8'h01); send_byte(8'h01);
      n_checks++; if (error !== 1'b1)     begin n_fail++; $display("FAIL ovf_error: got %b want 1", error); end
      n_checks++; if (rx_ready !== 1'b0)  begin n_fail++; $display("FAIL ovf_rx_ready: got %b want 0", rx_ready); end
      n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL ovf_done: got %b want 0", done); end
      repeat (3) @(posedge clk); #1;
      n_checks++; if (cpu_reset !== 1'b1)   begin n_fail++; $display("FAIL ovf_cpu_reset: got %b want 1", cpu_reset); end
      n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL ovf_writes: got %0d want 0", log_addr.size()); end
   endtask

   task automatic test_single();
      do_reload();
      clear_log();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef BOOT_CHECKSUM_EN
      send_byte(8'h0A);
`endif
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done); end
      @(posedge clk); #1;
      n_checks++;
      if (log_data.size() != 1 || log_data[0] !== 32'h04030201 || log_addr[0] !== 8'h00) begin
         n_fail++; $display("FAIL single_write: count %0d first %h, want 1 write of 04030201 at 00", log_data.size(), log_data.size() > 0 ? log_data[0] : 32'hx);
      end
`ifdef BOOT_CHECKSUM_EN
      do_reload();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h0B);
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL csum_bad_error: got %b want 1", error); end
      @(posedge clk); #1;
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL csum_bad_cpu_reset: got %b want 1", cpu_reset); end
      do_reload();
      n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL csum_reload_ready: got %b want 1", rx_ready); end
      n_checks++; if (error !== 1'b0)    begin n_fail++; $display("FAIL csum_reload_error: got %b want 0", error); end
`endif
   endtask

   task automatic test_back_to_back_full();
      logic [7:0]  b0, b1, b2, b3;
      logic [7:0]  sum;
      logic [31:0] exp_w [256];
      int          bad_spacing;
      do_reload();
      clear_log();
      sum = 8'h00;
      send_byte(8'h00); send_byte(8'h01);
      for (int w = 0; w < 256; w++) begin
         b0 = 8'(w); b1 = 8'(w) ^ 8'hA5; b2 = ~8'(w); b3 = 8'(w + 1);
         exp_w[w] = {b3, b2, b1, b0};
         sum = sum + b0 + b1 + b2 + b3;
         send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
      end
`ifdef BOOT_CHECKSUM_EN
      send_byte(sum);
`endif
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", done); end
      @(posedge clk); #1;
      n_checks++; if (log_addr.size() != 256) begin n_fail++; $display("FAIL full_write_count: got %0d want 256", log_addr.size()); end
      bad_spacing = 0;
      for (int i = 0; i < log_addr.size() && i < 256; i++) begin
         n_checks++;
         if (log_addr[i] !== 8'(i) || log_data[i] !== exp_w[i]) begin
            n_fail++; $display("FAIL full_word_%0d: got %h@%h want %h@%h", i, log_data[i], log_addr[i], exp_w[i], 8'(i));
         end
         if (i > 0 && log_cyc[i] - log_cyc[i-1] != 4) bad_spacing++;
      end
      n_checks++; if (bad_spacing != 0) begin n_fail++; $display("FAIL full_spacing: %0d gaps not 4 cycles, want 0", bad_spacing); end
      repeat (5) @(posedge clk); #1;
      n_checks++; if (log_addr.size() != 256) begin n_fail++; $display("FAIL full_no_wrap: got %0d writes want 256", log_addr.size()); end
      n_checks++; if (cpu_reset !== 1'b0)     begin n_fail++; $display("FAIL full_cpu_reset: got %b want 0", cpu_reset); end
   endtask

   task automatic test_midword_reload();
      do_reload();
      clear_log();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
      // Reload with a byte offered in the same cycle; that byte is dropped.
      reload = 1'b1; rx_valid = 1'b1; rx_data = 8'h07;
      @(posedge clk); #1;
      reload = 1'b0; rx_valid = 1'b0;
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_reset_reload: got %b want 1", cpu_reset); end
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_reset_loading: got %b want 1", cpu_reset); end
      send_byte(8'h44);
`ifdef BOOT_CHECKSUM_EN
      send_byte(8'hAA);
`endif
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b want 1", done); end
      @(posedge clk); #1;
      n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_reset_release: got %b want 0", cpu_reset); end
      n_checks++;
      if (log_data.size() != 1 || log_addr[0] !== 8'h00 || log_data[0] !== 32'h44332211) begin
         n_fail++; $display("FAIL mid_write: count %0d first %h, want 1 write of 44332211 at 00", log_data.size(), log_data.size() > 0 ? log_data[0] : 32'hx);
      end
   endtask

   initial begin
      reset = 1'b1; reload = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      test_reset();
      test_basic();
      test_zero();
      test_overflow();
      test_single();
      test_back_to_back_full();
      test_midword_reload();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot sequencer for the single-cycle RISC-V CPU. It holds the CPU in reset, receives a program image as a byte stream over a valid/ready handshake, and assembles little-endian 32-bit words. It writes those words into instruction memory starting at word address 0, then releases the CPU reset. It sits between the byte source (UART receiver or bench) and the instruction-memory write port, and drives the CPU's `reset` input.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to its initial state.
- `reload`  in  1  synchronous request to restart loading.
- `rx_valid`  in  1  byte source has a byte.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  loader can accept a byte. A byte transfers on an edge where `rx_valid & rx_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  word data.
- `cpu_reset`  out  1  drives the CPU `reset`; high while loading or in error.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERR.

## Operation
Image format:
- Byte 0 and byte 1 give a 16-bit word count N, little-endian.
- Then 4·N payload bytes, little-endian per word.
- Then one checksum byte, only when `BOOT_CHECKSUM_EN` is defined.

FSM states: LEN0, LEN1, DATA, CSUM, RUN, ERR.
- LEN0 → LEN1 on handshake; latch low byte of N.
- LEN1 on handshake, with N' = the complete 16-bit count:
  - N' > 2^ADDR_W → ERR.
  - N' = 0 → CSUM if enabled, else RUN.
  - Otherwise → DATA.
- DATA:
  - Byte lane counter 0..3 shifts each accepted byte into the word register; lane 0 goes to bits [7:0].
  - On the 4th byte: register `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word. Word index then increments.
  - After word N−1 is issued: → CSUM if enabled, else RUN.
- CSUM: on handshake, compare against the running checksum. Match → RUN; mismatch → ERR.
- RUN and ERR: hold until `reload` or `reset`.
- `rx_ready` = 1 in LEN0, LEN1, DATA and CSUM; 0 in RUN and ERR.
- `cpu_reset` = 0 only in RUN.
- `done` = 1 only in RUN; `error` = 1 only in ERR.
- Word index never wraps. Because N ≤ 2^ADDR_W, the largest address written is 2^ADDR_W − 1. The word index needs ADDR_W+1 bits internally.
- `reload`, from any state: → LEN0 at the next edge.
  - Clears word index, lane counter and checksum.
  - `cpu_reset` returns to 1.
  - A byte handshaking in the same cycle is dropped.
  - Mid-load, a reload abandons the partial word; already-written words are not erased.
- Priority: `reset` > `reload` > handshake.

## Timing
- Reset values, after an edge with `reset`=1:
  - state LEN0, all counters 0, checksum 0.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_reset`=1, `done`=0, `error`=0, `rx_ready`=1.
- A handshake sampled on an edge with `reset`=1 is ignored.
- `rx_ready`, `done`, `error` and `cpu_reset` are decoded from registered state, so they are glitch-free and change only at edges. `rx_ready` never depends combinationally on `rx_valid`.
- Word write latency: `imem_we` is high for exactly the one cycle after the edge that accepts a word's 4th byte. Back-to-back words produce pulses at least 4 cycles apart.
- Release after the last word:
  - Edge E0 accepts the final byte: `imem_we` pulses during E0→E1, and state becomes RUN at E0.
  - `cpu_reset` falls at E1, which is registered one stage after the state change.
  - The CPU's first active edge is E2, after the final write has completed.
- With the checksum enabled, `cpu_reset` falls one edge after the CSUM-accept edge.
- The source may hold `rx_valid` high continuously; the loader sustains 1 byte per cycle.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - Checksum = 8-bit modulo-256 sum of all payload bytes; the count bytes are excluded.
  - The CSUM state is present, and a mismatch enters ERR with `cpu_reset` held at 1.
  - For N=0, the expected checksum byte is 0x00.
- `BOOT_CHECKSUM_EN` undefined:
  - No CSUM state and no checksum logic.
  - The block enters RUN directly after the last word, or after LEN1 when N=0.

## Test plan
- Reset, then stream 02 00 13 05 50 00 73 00 10 00:
  - Writes addr0=0x00500513, then addr1=0x00100073.
  - `cpu_reset` falls 1 edge after RUN is entered.
  - `done`=1 and `rx_ready`=0.
- N=0, stream 00 00, plus 00 if checksum enabled → RUN with no `imem_we` pulse.
- ADDR_W=8 with N=257 (01 01) → ERR after 2nd byte; `cpu_reset` stays 1; no writes.
- N=256, full image → last write at addr 0xFF, then RUN; no wrap to 0.
- Checksum enabled, N=1, word bytes 01 02 03 04:
  - Checksum 0x0A → RUN.
  - Checksum 0x0B → ERR.
  - Then `reload` → LEN0, `rx_ready`=1.
- Mid-word `reload` after 2 payload bytes, then a fresh image:
  - The partial word is never written.
  - The new image writes from addr 0.
  - `cpu_reset` stays 1 until the new image completes.
